// File: rtl/fp32_mul_worker.sv
// fp32_mul_worker: binary32 round-to-nearest-even multiplier behind stb/ack handshakes on A, B and Z.
// Define FP32_MUL_DENORM_EN for full subnormal support; otherwise subnormals flush to signed zero.
module fp32_mul_worker (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    localparam logic [2:0] GET_OPS   = 3'd0;
    localparam logic [2:0] UNPACK    = 3'd1;
    localparam logic [2:0] SPECIAL   = 3'd2;
    localparam logic [2:0] MULTIPLY  = 3'd3;
    localparam logic [2:0] NORMALISE = 3'd4;
    localparam logic [2:0] ROUND     = 3'd5;
    localparam logic [2:0] PACK      = 3'd6;
    localparam logic [2:0] PUT_Z     = 3'd7;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    logic [2:0]        state_reg;
    logic              a_ack_reg, b_ack_reg, a_got_reg, b_got_reg;
    logic [31:0]       op_raw_reg [2];
    logic [23:0]       op_m_reg [2];
    logic signed [9:0] op_e_reg [2];
    logic [1:0]        op_zero_reg, op_inf_reg, op_nan_reg;
    logic [47:0]       prod_reg;
    logic signed [9:0] z_e_reg;
    logic [23:0]       z_m_reg;
    logic              guard_reg, round_reg, sticky_reg;
    logic [31:0]       z_reg;
    logic              z_stb_reg;
`ifdef FP32_MUL_DENORM_EN
    logic              unpacked_reg, normed_reg;
`endif

    logic              a_take, b_take, z_s;
    logic [7:0]        op_exp [2];
    logic [22:0]       op_frac [2];
    logic [1:0]        op_exp_max, op_exp_min, op_frac_nz;

    assign a_take = input_a_stb && a_ack_reg;
    assign b_take = input_b_stb && b_ack_reg;
    assign z_s    = op_raw_reg[0][31] ^ op_raw_reg[1][31];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dec
            assign op_exp[gi]     = op_raw_reg[gi][30:23];
            assign op_frac[gi]    = op_raw_reg[gi][22:0];
            assign op_exp_max[gi] = &op_exp[gi];
            assign op_exp_min[gi] = ~|op_exp[gi];
            assign op_frac_nz[gi] = |op_frac[gi];
        end
    endgenerate

    logic        special_hit;
    logic [31:0] special_z;
    always_comb begin
        special_hit = 1'b1;
        special_z   = QNAN;
        if (|op_nan_reg)
            special_z = QNAN;
        else if (|op_inf_reg)
            special_z = (|op_zero_reg) ? QNAN : {z_s, 8'hFF, 23'd0};
        else if (|op_zero_reg)
            special_z = {z_s, 31'd0};
        else
            special_hit = 1'b0;
    end

    // Both mantissas carry the implicit bit, so the product MSB is at bit 47 or 46.
    logic [23:0]       norm_m;
    logic              norm_g, norm_r, norm_s;
    logic signed [9:0] norm_e;
    always_comb begin
        if (prod_reg[47]) begin
            norm_m = prod_reg[47:24];
            norm_g = prod_reg[23];
            norm_r = prod_reg[22];
            norm_s = |prod_reg[21:0];
            norm_e = z_e_reg + 10'sd1;
        end else begin
            norm_m = prod_reg[46:23];
            norm_g = prod_reg[22];
            norm_r = prod_reg[21];
            norm_s = |prod_reg[20:0];
            norm_e = z_e_reg;
        end
    end

    logic        round_up;
    logic [7:0]  z_biased;
    logic [31:0] pack_z;
    assign round_up = guard_reg && (round_reg || sticky_reg || z_m_reg[0]);
    assign z_biased = 8'(z_e_reg + 10'sd127);
    always_comb begin
        if (z_e_reg > 10'sd127)
            pack_z = {z_s, 8'hFF, 23'd0};
`ifdef FP32_MUL_DENORM_EN
        else if (!z_m_reg[23])
            pack_z = {z_s, 8'd0, z_m_reg[22:0]};
`else
        else if (z_e_reg < -10'sd126)
            pack_z = {z_s, 31'd0};
`endif
        else
            pack_z = {z_s, z_biased, z_m_reg[22:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= GET_OPS;
            a_ack_reg     <= 1'b0;
            b_ack_reg     <= 1'b0;
            a_got_reg     <= 1'b0;
            b_got_reg     <= 1'b0;
            op_raw_reg[0] <= 32'd0;
            op_raw_reg[1] <= 32'd0;
            op_m_reg[0]   <= 24'd0;
            op_m_reg[1]   <= 24'd0;
            op_e_reg[0]   <= 10'sd0;
            op_e_reg[1]   <= 10'sd0;
            op_zero_reg   <= 2'b00;
            op_inf_reg    <= 2'b00;
            op_nan_reg    <= 2'b00;
            prod_reg      <= 48'd0;
            z_e_reg       <= 10'sd0;
            z_m_reg       <= 24'd0;
            guard_reg     <= 1'b0;
            round_reg     <= 1'b0;
            sticky_reg    <= 1'b0;
            z_reg         <= 32'd0;
            z_stb_reg     <= 1'b0;
`ifdef FP32_MUL_DENORM_EN
            unpacked_reg  <= 1'b0;
            normed_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                GET_OPS: begin
                    if (a_take) begin
                        op_raw_reg[0] <= input_a;
                        a_ack_reg     <= 1'b0;
                        a_got_reg     <= 1'b1;
                    end else if (!a_got_reg) begin
                        a_ack_reg <= 1'b1;
                    end
                    if (b_take) begin
                        op_raw_reg[1] <= input_b;
                        b_ack_reg     <= 1'b0;
                        b_got_reg     <= 1'b1;
                    end else if (!b_got_reg) begin
                        b_ack_reg <= 1'b1;
                    end
                    if ((a_got_reg || a_take) && (b_got_reg || b_take)) begin
                        a_got_reg <= 1'b0;
                        b_got_reg <= 1'b0;
                        state_reg <= UNPACK;
                    end
                end
                UNPACK: begin
`ifdef FP32_MUL_DENORM_EN
                    if (!unpacked_reg) begin
                        for (int i = 0; i < 2; i++) begin
                            op_nan_reg[i]  <= op_exp_max[i] && op_frac_nz[i];
                            op_inf_reg[i]  <= op_exp_max[i] && !op_frac_nz[i];
                            op_zero_reg[i] <= op_exp_min[i] && !op_frac_nz[i];
                            op_e_reg[i]    <= op_exp_min[i] ? -10'sd126
                                                            : $signed({2'b00, op_exp[i]}) - 10'sd127;
                            op_m_reg[i]    <= {!op_exp_min[i], op_frac[i]};
                        end
                        unpacked_reg <= 1'b1;
                    end else if (!op_m_reg[0][23] && !op_zero_reg[0]) begin
                        op_m_reg[0] <= op_m_reg[0] << 1;
                        op_e_reg[0] <= op_e_reg[0] - 10'sd1;
                    end else if (!op_m_reg[1][23] && !op_zero_reg[1]) begin
                        op_m_reg[1] <= op_m_reg[1] << 1;
                        op_e_reg[1] <= op_e_reg[1] - 10'sd1;
                    end else begin
                        unpacked_reg <= 1'b0;
                        state_reg    <= SPECIAL;
                    end
`else
                    // Subnormal inputs (exponent field 0) are treated as zero.
                    for (int i = 0; i < 2; i++) begin
                        op_nan_reg[i]  <= op_exp_max[i] && op_frac_nz[i];
                        op_inf_reg[i]  <= op_exp_max[i] && !op_frac_nz[i];
                        op_zero_reg[i] <= op_exp_min[i];
                        op_e_reg[i]    <= $signed({2'b00, op_exp[i]}) - 10'sd127;
                        op_m_reg[i]    <= {1'b1, op_frac[i]};
                    end
                    state_reg <= SPECIAL;
`endif
                end
                SPECIAL: begin
                    // Special results are registered here and presented one edge later in PUT_Z.
                    if (special_hit) begin
                        z_reg     <= special_z;
                        state_reg <= PUT_Z;
                    end else begin
                        state_reg <= MULTIPLY;
                    end
                end
                MULTIPLY: begin
                    prod_reg  <= 48'(op_m_reg[0]) * 48'(op_m_reg[1]);
                    z_e_reg   <= op_e_reg[0] + op_e_reg[1];
                    state_reg <= NORMALISE;
                end
                NORMALISE: begin
`ifdef FP32_MUL_DENORM_EN
                    if (!normed_reg) begin
                        z_m_reg    <= norm_m;
                        guard_reg  <= norm_g;
                        round_reg  <= norm_r;
                        sticky_reg <= norm_s;
                        z_e_reg    <= norm_e;
                        normed_reg <= 1'b1;
                    end else if (z_e_reg < -10'sd126) begin
                        z_m_reg    <= z_m_reg >> 1;
                        guard_reg  <= z_m_reg[0];
                        round_reg  <= guard_reg;
                        sticky_reg <= sticky_reg | round_reg;
                        z_e_reg    <= z_e_reg + 10'sd1;
                    end else begin
                        normed_reg <= 1'b0;
                        state_reg  <= ROUND;
                    end
`else
                    z_m_reg    <= norm_m;
                    guard_reg  <= norm_g;
                    round_reg  <= norm_r;
                    sticky_reg <= norm_s;
                    z_e_reg    <= norm_e;
                    state_reg  <= ROUND;
`endif
                end
                ROUND: begin
                    if (round_up) begin
                        if (&z_m_reg) begin
                            z_m_reg <= 24'h80_0000;
                            z_e_reg <= z_e_reg + 10'sd1;
                        end else begin
                            z_m_reg <= z_m_reg + 24'd1;
                        end
                    end
                    state_reg <= PACK;
                end
                PACK: begin
                    z_reg     <= pack_z;
                    z_stb_reg <= 1'b1;
                    state_reg <= PUT_Z;
                end
                PUT_Z: begin
                    if (!z_stb_reg) begin
                        z_stb_reg <= 1'b1;
                    end else if (output_z_ack) begin
                        z_stb_reg <= 1'b0;
                        state_reg <= GET_OPS;
                    end
                end
                default: state_reg <= GET_OPS;
            endcase
        end
    end

    assign input_a_ack  = a_ack_reg;
    assign input_b_ack  = b_ack_reg;
    assign output_z     = z_reg;
    assign output_z_stb = z_stb_reg;
endmodule

// File: tb/tb_fp32_mul_worker.sv
// Self-checking bench for fp32_mul_worker: directed vector table, handshake corner cases,
// and random operands checked against an integer-arithmetic binary32 product model.
module tb_fp32_mul_worker;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] input_a, input_b;
    logic        input_a_stb, input_b_stb, output_z_ack;
    logic        input_a_ack, input_b_ack, output_z_stb;
    logic [31:0] output_z;

    int checks = 0;
    int errors = 0;

    fp32_mul_worker dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .input_b      (input_b),
        .input_b_stb  (input_b_stb),
        .input_b_ack  (input_b_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        int          lat;
    } vec_t;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact integer product of the significands, rounded to 24 bits by remainder compare.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, k, sh, e_val;
        logic s;
        longint unsigned p, q, rem, half;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC0_0000;
        if (ea == 255 || eb == 255) begin
            if (ea == 0 || eb == 0) return 32'h7FC0_0000;
            return {s, 8'hFF, 23'd0};
        end
        if (ea == 0 || eb == 0) return {s, 31'd0};
        p  = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        k  = (p >= (64'd1 << 47)) ? 47 : 46;
        e_val = (ea - 127) + (eb - 127) + (k - 46);
        sh   = k - 23;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e_val++;
        end
        if (e_val > 127) return {s, 8'hFF, 23'd0};
        if (e_val < -126) return {s, 31'd0};
        return {s, 8'(e_val + 127), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op(input int mode);
        logic [31:0] r;
        int pick;
        r = $urandom();
        if (mode == 1) begin
            r[30:23] = 8'($urandom_range(190, 64));
        end else if (mode == 2) begin
            pick = $urandom_range(7, 0);
            case (pick)
                0: r = 32'h0000_0000;
                1: r = 32'h8000_0000;
                2: r = 32'h7F80_0000;
                3: r = 32'hFF80_0000;
                4: r = 32'h7FC0_0000;
                5: r = 32'h7F80_0001;
                6: r = 32'h0000_0001;
                default: r = 32'h3F80_0000;
            endcase
        end
        return r;
    endfunction

    // Present A and B (each after its own delay) and return #1 after the edge capturing the last one.
    task automatic send_ops(input logic [31:0] a, input logic [31:0] b, input int a_delay,
                            input int b_delay, output bit a_ack_held);
        int k;
        bit a_done, b_done, ta, tb;
        k = 0; a_done = 0; b_done = 0; a_ack_held = 1;
        input_a = a;
        input_b = b;
        while (!(a_done && b_done) && k < 100) begin
            input_a_stb = !a_done && (k >= a_delay);
            input_b_stb = !b_done && (k >= b_delay);
            if (k >= 1 && !a_done && !input_a_ack) a_ack_held = 0;
            ta = input_a_stb && input_a_ack;
            tb = input_b_stb && input_b_ack;
            @(posedge clk); #1;
            k++;
            if (ta) begin a_done = 1; input_a_stb = 0; end
            if (tb) begin b_done = 1; input_b_stb = 0; end
        end
        input_a_stb = 0;
        input_b_stb = 0;
        if (!(a_done && b_done)) check_int("operand_capture_timeout", 0, 1);
    endtask

    task automatic wait_z(output int lat);
        lat = 0;
        while (!output_z_stb && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!output_z_stb) check_int("output_stb_timeout", 0, 1);
    endtask

    task automatic finish_op();
        output_z_ack = 1;
        @(posedge clk); #1;
        output_z_ack = 0;
        check_int("stb_drop_after_ack", int'(output_z_stb), 0);
    endtask

    vec_t vecs[10];
    logic [31:0] z_hold, ra, rb, rexp;
    int lat;
    bit held;

    initial begin
        vecs[0] = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 6};
        vecs[1] = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 6};
        vecs[2] = '{32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 6};
        vecs[3] = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3};
        vecs[4] = '{32'h7FA0_0000, 32'h3F80_0000, 32'h7FC0_0000, 3};
`ifdef FP32_MUL_DENORM_EN
        vecs[5] = '{32'h0080_0000, 32'h3F00_0000, 32'h0040_0000, 6};
`else
        vecs[5] = '{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 6};
`endif
        vecs[6] = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3};
        vecs[7] = '{32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 3};
        vecs[8] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 6};
        vecs[9] = '{32'hC000_0000, 32'hC000_0000, 32'h4080_0000, 6};

        rst = 1; input_a = 0; input_b = 0;
        input_a_stb = 0; input_b_stb = 0; output_z_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        check_int("reset_a_ack", int'(input_a_ack), 0);
        check_int("reset_b_ack", int'(input_b_ack), 0);
        check_int("reset_z_stb", int'(output_z_stb), 0);
        check32("reset_z", output_z, 32'h0);
        rst = 0;
        @(posedge clk); #1;
        check_int("first_edge_a_ack", int'(input_a_ack), 1);
        check_int("first_edge_b_ack", int'(input_b_ack), 1);

        for (int i = 0; i < 10; i++) begin
            send_ops(vecs[i].a, vecs[i].b, 0, 0, held);
            wait_z(lat);
            $display("vec %0d a=%08h b=%08h z=%08h want=%08h lat=%0d", i, vecs[i].a, vecs[i].b,
                     output_z, vecs[i].z, lat);
            check32($sformatf("vec%0d_z", i), output_z, vecs[i].z);
`ifndef FP32_MUL_DENORM_EN
            check_int($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
`endif
            finish_op();
        end

        // B arrives 5 cycles before A; A's ack must stay up the whole time.
        send_ops(32'hBFC0_0000, 32'h4080_0000, 5, 0, held);
        wait_z(lat);
        $display("late_a a=BFC00000 b=40800000 z=%08h ack_held=%0d", output_z, held);
        check32("late_a_z", output_z, 32'hC0C0_0000);
        check_int("late_a_ack_held", int'(held), 1);
        finish_op();

        // Backpressure: result and strobe hold while no operand is acked.
        send_ops(32'h4000_0000, 32'h4040_0000, 0, 0, held);
        wait_z(lat);
        z_hold = output_z;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check_int("bp_stb", int'(output_z_stb), 1);
            check32("bp_z", output_z, z_hold);
            check_int("bp_acks", int'(input_a_ack | input_b_ack), 0);
        end
        $display("backpressure z=%08h held 10 cycles", output_z);
        check32("bp_value", z_hold, 32'h40C0_0000);
        finish_op();

        // Reset while the product is in MULTIPLY.
        send_ops(32'h4000_0000, 32'h4040_0000, 0, 0, held);
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        #1;
        check_int("midrst_a_ack", int'(input_a_ack), 0);
        check_int("midrst_b_ack", int'(input_b_ack), 0);
        check_int("midrst_stb", int'(output_z_stb), 0);
        check32("midrst_z", output_z, 32'h0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        check_int("midrst_reack", int'(input_a_ack & input_b_ack), 1);
        held = 0;
        for (int c = 0; c < 12; c++) begin
            if (output_z_stb) held = 1;
            @(posedge clk); #1;
        end
        check_int("midrst_no_stb", int'(held), 0);
        $display("reset mid-operation: no output strobe afterwards");

        for (int i = 0; i < 120; i++) begin
`ifdef FP32_MUL_DENORM_EN
            ra = rand_op(1);
            rb = rand_op(1);
`else
            ra = rand_op($urandom_range(2, 0));
            rb = rand_op($urandom_range(2, 0));
`endif
            rexp = ref_mul(ra, rb);
            send_ops(ra, rb, $urandom_range(2, 0), $urandom_range(2, 0), held);
            wait_z(lat);
            $display("rnd %0d a=%08h b=%08h z=%08h want=%08h", i, ra, rb, output_z, rexp);
            check32($sformatf("rnd%0d_z", i), output_z, rexp);
            finish_op();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
